// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client DDR request arbiter.
package mem_arb_pkg;

   // Arbiter FSM encoding; also exposed on the debug state output.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // Which client owns the in-flight request.
   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_t;

   // Default watchdog limit in cycles spent waiting in ISSUE.
   localparam int DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Client and controller signals of the DDR request arbiter.
//
// Handshake: a client raises its request (i_ren, d_ren, d_wen) with its
// address/data fields and holds all of them stable until its own valid
// pulses for exactly one cycle; the request must be dropped after that
// pulse or it is treated as a new request. Toward the controller the
// arbiter holds ren_mem/wen_mem and the fields stable until valid_mem
// is seen high, then drops the strobes and waits for valid_mem to go
// low before it may issue again.
interface mem_req_arbiter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic [ADDR_WIDTH-1:0]   i_addr;
   logic                    i_ren;
   logic [DATA_WIDTH-1:0]   i_rdata;
   logic                    i_valid;

   logic [ADDR_WIDTH-1:0]   d_addr;
   logic                    d_ren;
   logic                    d_wen;
   logic [DATA_WIDTH-1:0]   d_wdata;
   logic [DATA_WIDTH/8-1:0] d_wmask;
   logic [DATA_WIDTH-1:0]   d_rdata;
   logic                    d_valid;

   logic [ADDR_WIDTH-1:0]   addr_mem;
   logic [DATA_WIDTH-1:0]   wdata_mem;
   logic [DATA_WIDTH/8-1:0] wmask_mem;
   logic                    ren_mem;
   logic                    wen_mem;
   logic [DATA_WIDTH-1:0]   rdata_mem;
   logic                    valid_mem;

   logic                    err_timeout;
   logic                    busy;

   // Arbiter side.
   modport slave (
      input  i_addr, i_ren, d_addr, d_ren, d_wen, d_wdata, d_wmask,
             rdata_mem, valid_mem,
      output i_rdata, i_valid, d_rdata, d_valid,
             addr_mem, wdata_mem, wmask_mem, ren_mem, wen_mem,
             err_timeout, busy
   );

   // Environment side: clients plus controller.
   modport master (
      output i_addr, i_ren, d_addr, d_ren, d_wen, d_wdata, d_wmask,
             rdata_mem, valid_mem,
      input  i_rdata, i_valid, d_rdata, d_valid,
             addr_mem, wdata_mem, wmask_mem, ren_mem, wen_mem,
             err_timeout, busy
   );
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-requester round-robin picker: req[0] is I, req[1] is D.
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last,
   output grant_t     gnt,
   output logic       any
);

   // On a tie the client that was not served last wins.
   always_comb begin
      any = |req;
      gnt = GNT_D;
      if (req == 2'b11)
         gnt = (last == GNT_I) ? GNT_D : GNT_I;
      else if (req[0])
         gnt = GNT_I;
      else
         gnt = GNT_D;
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// Fetch/data front end for the DDR controller: one request at a time,
// round-robin between clients, one-cycle completion pulse per client.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
   input  logic       ui_clk,
   input  logic       ui_rst_n,
   mem_req_arbiter_if.slave bus,
   output arb_state_t o_dbg_state
);

   localparam int MW = DATA_WIDTH / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT - 1);

   arb_state_t            r_state;
   grant_t                r_last;
   grant_t                r_gnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [MW-1:0]         r_wmask;
   logic                  r_ren;
   logic                  r_wen;
   logic [DATA_WIDTH-1:0] r_i_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_i_valid;
   logic                  r_d_valid;
   logic [CW-1:0]         r_wd;
   logic                  r_err;

   logic [1:0]            w_req;
   grant_t                w_gnt;
   logic                  w_any;

   // A client completing this cycle is masked so its stale request is not re-granted.
   assign w_req = {(bus.d_ren | bus.d_wen) & ~r_d_valid, bus.i_ren & ~r_i_valid};

   mem_arb_rr2 u_rr2 (
      .req  (w_req),
      .last (r_last),
      .gnt  (w_gnt),
      .any  (w_any)
   );

   // Request FSM: latch on grant, hold until valid_mem, then wait for it to drop.
   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         r_state   <= IDLE;
         r_last    <= GNT_I;
         r_gnt     <= GNT_I;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_ren     <= 1'b0;
         r_wen     <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;
      end else begin
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_gnt;
                  r_state <= ISSUE;
                  if (w_gnt == GNT_I) begin
                     r_addr  <= bus.i_addr;
                     r_wdata <= '0;
                     r_wmask <= '0;
                     r_ren   <= 1'b1;
                     r_wen   <= 1'b0;
                  end else if (bus.d_wen) begin
                     r_addr  <= bus.d_addr;
                     r_wdata <= bus.d_wdata;
                     r_wmask <= bus.d_wmask;
                     r_ren   <= 1'b0;
                     r_wen   <= 1'b1;
                  end else begin
                     r_addr  <= bus.d_addr;
                     r_wdata <= '0;
                     r_wmask <= '0;
                     r_ren   <= 1'b1;
                     r_wen   <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (bus.valid_mem) begin
                  r_ren   <= 1'b0;
                  r_wen   <= 1'b0;
                  r_last  <= r_gnt;
                  r_state <= DRAIN;
                  if (r_gnt == GNT_I) begin
                     r_i_valid <= 1'b1;
                     r_i_rdata <= bus.rdata_mem;
                  end else begin
                     r_d_valid <= 1'b1;
                     if (r_ren)
                        r_d_rdata <= bus.rdata_mem;
                  end
               end
            end
            DRAIN: begin
               if (!bus.valid_mem)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Watchdog: counts ISSUE cycles from each grant; the error is sticky until reset.
   always_ff @(posedge ui_clk or negedge ui_rst_n) begin
      if (!ui_rst_n) begin
         r_wd  <= '0;
         r_err <= 1'b0;
      end else if (r_state != ISSUE) begin
         r_wd <= '0;
      end else if (!bus.valid_mem) begin
         if (r_wd == WD_MAX)
            r_err <= 1'b1;
         else
            r_wd <= r_wd + CW'(1);
      end
   end

   assign bus.addr_mem    = r_addr;
   assign bus.wdata_mem   = r_wdata;
   assign bus.wmask_mem   = r_wmask;
   assign bus.ren_mem     = r_ren;
   assign bus.wen_mem     = r_wen;
   assign bus.i_rdata     = r_i_rdata;
   assign bus.i_valid     = r_i_valid;
   assign bus.d_rdata     = r_d_rdata;
   assign bus.d_valid     = r_d_valid;
   assign bus.err_timeout = r_err;
   assign bus.busy        = (r_state != IDLE);
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter with a transaction-level model.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic ui_clk = 1'b0;
  logic ui_rst_n = 1'b0;
  arb_state_t dbg_state;

  always #5 ui_clk = ~ui_clk;

  mem_req_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus();

  mem_req_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(16)) dut (
    .ui_clk      (ui_clk),
    .ui_rst_n    (ui_rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- model state ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit pend_i, pend_d, m_dwr;
  logic [63:0] m_iaddr, m_daddr, m_dwdata;
  logic [7:0] m_dwmask;
  grant_t m_last;
  logic [63:0] exp_ird, exp_drd;
  logic [63:0] exp_q[$];

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Fair choice: alone wins; both pending -> the one not served last.
  function automatic grant_t predict_grant();
    if (pend_i && pend_d) return (m_last == GNT_I) ? GNT_D : GNT_I;
    return pend_i ? GNT_I : GNT_D;
  endfunction

  function automatic logic [1:0] exp_strb(input grant_t g);
    if (g == GNT_I) return 2'b10;
    return m_dwr ? 2'b01 : 2'b10;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_i_req(input logic [63:0] addr);
    bus.i_addr = addr;
    bus.i_ren = 1'b1;
    pend_i = 1'b1;
    m_iaddr = addr;
  endtask

  task automatic set_d_req(input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [7:0] wmask, input bit wr, input bit both);
    bus.d_addr = addr;
    bus.d_wdata = wdata;
    bus.d_wmask = wmask;
    bus.d_wen = wr;
    bus.d_ren = !wr || both;
    pend_d = 1'b1;
    m_dwr = wr;
    m_daddr = addr;
    m_dwdata = wdata;
    m_dwmask = wmask;
  endtask

  task automatic drop_req(input grant_t g);
    if (g == GNT_I) begin
      bus.i_ren = 1'b0;
      pend_i = 1'b0;
    end else begin
      bus.d_ren = 1'b0;
      bus.d_wen = 1'b0;
      pend_d = 1'b0;
    end
  endtask

  task automatic wait_grant(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(posedge ui_clk); #1;
      n++;
      if (bus.ren_mem || bus.wen_mem) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant_latency", 64'(n), 64'(1));
  endtask

  task automatic check_fields(input grant_t g);
    check("grant_strb", 64'({bus.ren_mem, bus.wen_mem}), 64'(exp_strb(g)));
    if (g == GNT_I) begin
      check("grant_addr_i", bus.addr_mem, m_iaddr);
      check("grant_wdata_i", bus.wdata_mem, 64'(0));
      check("grant_wmask_i", 64'(bus.wmask_mem), 64'(0));
    end else begin
      check("grant_addr_d", bus.addr_mem, m_daddr);
      check("grant_wdata_d", bus.wdata_mem, m_dwr ? m_dwdata : 64'(0));
      check("grant_wmask_d", 64'(bus.wmask_mem), m_dwr ? 64'(m_dwmask) : 64'(0));
    end
    check("grant_busy", 64'(bus.busy), 64'(1));
  endtask

  // One full transaction acting as the controller.
  task automatic serve(input logic [63:0] rdata, input int lat, input int hold,
                       input int drop_dly, input bit scramble);
    grant_t g;
    bit ok;
    int k;
    logic [63:0] w;
    g = predict_grant();
    wait_grant(ok);
    if (!ok) return;
    check_fields(g);
    if (scramble) begin
      if (g == GNT_I) bus.i_addr = rnd64();
      else begin
        bus.d_addr = rnd64();
        bus.d_wdata = rnd64();
        bus.d_wmask = 8'($urandom());
      end
    end
    for (int j = 0; j < lat; j++) begin
      @(posedge ui_clk); #1;
      check("issue_addr", bus.addr_mem, (g == GNT_I) ? m_iaddr : m_daddr);
      check("issue_strb", 64'({bus.ren_mem, bus.wen_mem}), 64'(exp_strb(g)));
      check("issue_valid", 64'({bus.i_valid, bus.d_valid}), 64'(0));
    end
    bus.rdata_mem = rdata;
    bus.valid_mem = 1'b1;
    if (g == GNT_I) exp_ird = rdata;
    else if (!m_dwr) exp_drd = rdata;
    exp_q.push_back((g == GNT_I) ? exp_ird : exp_drd);
    @(posedge ui_clk); #1;
    check("done_strb", 64'({bus.ren_mem, bus.wen_mem}), 64'(0));
    check("done_valid", 64'({bus.i_valid, bus.d_valid}), (g == GNT_I) ? 64'(2) : 64'(1));
    w = exp_q.pop_front();
    if (g == GNT_I) begin
      check("i_rdata", bus.i_rdata, w);
      check("d_rdata_keep", bus.d_rdata, exp_drd);
    end else begin
      check("d_rdata", bus.d_rdata, w);
      check("i_rdata_keep", bus.i_rdata, exp_ird);
    end
    bus.rdata_mem = rnd64();
    m_last = g;
    k = 0;
    forever begin
      if (k == drop_dly) drop_req(g);
      if (k == hold) bus.valid_mem = 1'b0;
      if (k >= hold && k >= drop_dly) break;
      @(posedge ui_clk); #1;
      k++;
      check("drain_valid", 64'({bus.i_valid, bus.d_valid}), 64'(0));
      check("drain_strb", 64'({bus.ren_mem, bus.wen_mem}), 64'(0));
      check("drain_busy", 64'(bus.busy), (k <= hold) ? 64'(1) : 64'(0));
    end
    if (k == hold) begin
      @(posedge ui_clk); #1;
      check("idle_busy", 64'(bus.busy), 64'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strb"}, 64'({bus.ren_mem, bus.wen_mem}), 64'(0));
    check({tag, "_valid"}, 64'({bus.i_valid, bus.d_valid}), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_err"}, 64'(bus.err_timeout), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    bus.i_addr = '0; bus.i_ren = 1'b0;
    bus.d_addr = '0; bus.d_ren = 1'b0; bus.d_wen = 1'b0;
    bus.d_wdata = '0; bus.d_wmask = '0;
    bus.rdata_mem = '0; bus.valid_mem = 1'b0;
    pend_i = 0; pend_d = 0; m_dwr = 0; m_last = GNT_I;
    exp_ird = '0; exp_drd = '0;

    // reset values
    #12;
    check_all_zero("rst");
    check("rst_addr", bus.addr_mem, 64'(0));
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 64'(0));
    @(posedge ui_clk); #1;
    ui_rst_n = 1'b1;
    @(posedge ui_clk); #1;
    check_all_zero("post_rst");

    // single fetch, held one cycle past the pulse (stale-request guard)
    set_i_req(64'h8000_0010);
    serve(64'hDEAD_BEEF_CAFE_F00D, 5, 1, 1, 1'b0);
    repeat (4) begin
      @(posedge ui_clk); #1;
      check("no_regrant", 64'({bus.ren_mem, bus.wen_mem}), 64'(0));
    end

    // store
    set_d_req(64'h88, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, 1'b0);
    serve(rnd64(), 3, 0, 0, 1'b0);

    // watchdog: controller never answers
    set_i_req(rnd64());
    wait_grant(ok);
    check_fields(GNT_I);
    for (int k = 1; k <= 16; k++) begin
      @(posedge ui_clk); #1;
      if (k == 15) check("wd_before", 64'(bus.err_timeout), 64'(0));
      if (k == 16) begin
        check("wd_set", 64'(bus.err_timeout), 64'(1));
        check("wd_strb_held", 64'({bus.ren_mem, bus.wen_mem}), 64'(2));
      end
    end

    // asynchronous reset while in ISSUE
    #2 ui_rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    set_d_req(rnd64(), '0, '0, 1'b0, 1'b0);
    m_last = GNT_I; exp_ird = '0; exp_drd = '0;
    @(posedge ui_clk); #1;
    check("rst_hold_state", 64'(dbg_state), 64'(IDLE));
    ui_rst_n = 1'b1;

    // contention: both held; expect D, I, D, I
    for (int t = 0; t < 4; t++) begin
      check("rr_predict", 64'(predict_grant()), (t % 2 == 0) ? 64'(GNT_D) : 64'(GNT_I));
      serve(rnd64(), $urandom_range(0, 3), $urandom_range(0, 2), 0, 1'b0);
      if (!pend_i) set_i_req(rnd64());
      if (!pend_d) set_d_req(rnd64(), rnd64(), 8'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    // random traffic
    for (int t = 0; t < 60; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) set_i_req(rnd64());
      if (!pend_d && $urandom_range(0, 1) == 1)
        set_d_req(rnd64(), rnd64(), 8'($urandom()), 1'($urandom()), 1'($urandom()));
      if (!pend_i && !pend_d) set_i_req(rnd64());
      serve(rnd64(), $urandom_range(0, 6), $urandom_range(0, 3),
            $urandom_range(0, 1), 1'($urandom()));
    end
    check("final_err", 64'(bus.err_timeout), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
